// File: rtl/reg_writeback_unit_pkg.sv
// Shared types for the writeback unit: data width, register address width and
// the queued writeback entry (destination register plus result data).
package reg_writeback_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_wb_fifo.sv
// Load-result buffer: synchronous FIFO of writeback entries with an
// occupancy counter. Push and pop may happen in the same cycle, including
// when full (the pop frees the slot the push fills).
module wb_fifo
    import reg_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback unit: merges ALU results and buffered load results into the single
// register-file write port and keeps a pending-write scoreboard for decode.
// Optional macro WB_BYPASS_EN adds writeback forwarding to decode sources.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int XLEN          = reg_writeback_unit_pkg::XLEN,
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    output logic                  hazard,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  rd_wb_valid,
    output logic [REG_ADDR_W-1:0] rd_wb,
    output logic [XLEN-1:0]       wb_data
`ifdef WB_BYPASS_EN
    ,
    output logic                  rs1_fwd_valid,
    output logic                  rs2_fwd_valid
`endif
);

    logic [31:0] pending;
    logic [31:0] pending_next;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        rd_hit;
    logic        issue_accept;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    wb_entry_t   fifo_head;
    wb_entry_t   ld_entry;

    logic        alu_take;
    logic        ld_keep;
    logic        sel_valid;
    wb_entry_t   sel_entry;

    assign ld_ready = !fifo_full;
    assign ld_entry = '{rd: ld_rd, data: ld_data};

    // Raw scoreboard lookups; register 0 is never pending.
    assign rs1_hit = (issue_rs1 != '0) && pending[issue_rs1];
    assign rs2_hit = (issue_rs2 != '0) && pending[issue_rs2];
    assign rd_hit  = (issue_rd  != '0) && pending[issue_rd];

`ifdef WB_BYPASS_EN
    logic rd_on_wb;
    assign rs1_fwd_valid = rd_wb_valid && (rd_wb == issue_rs1) && (issue_rs1 != '0);
    assign rs2_fwd_valid = rd_wb_valid && (rd_wb == issue_rs2) && (issue_rs2 != '0);
    // A WAW against the register being written this cycle is safe: the new set wins.
    assign rd_on_wb      = rd_wb_valid && (rd_wb == issue_rd);
    assign hazard = (rs1_hit && !rs1_fwd_valid) ||
                    (rs2_hit && !rs2_fwd_valid) ||
                    (rd_hit  && !rd_on_wb);
`else
    assign hazard = rs1_hit || rs2_hit || rd_hit;
`endif

    assign issue_accept = issue_valid && !hazard;

    // Next scoreboard: clear the register being written back, then apply the issue set.
    always_comb begin
        pending_next = pending;
        if (rd_wb_valid) begin
            pending_next[rd_wb] = 1'b0;
        end
        if (issue_accept && (issue_rd != '0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // rd=0 results are dropped; a rd=0 load still completes its handshake.
    assign alu_take = alu_valid && (alu_rd != '0);
    assign ld_keep  = ld_valid && ld_ready && (ld_rd != '0);

    // Output priority: ALU, then FIFO head, then an incoming load straight through.
    always_comb begin
        sel_valid = 1'b0;
        sel_entry = ld_entry;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        if (alu_take) begin
            sel_valid = 1'b1;
            sel_entry = '{rd: alu_rd, data: alu_data};
            fifo_push = ld_keep;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_entry = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = ld_keep;
        end else if (ld_keep) begin
            sel_valid = 1'b1;
            sel_entry = ld_entry;
        end
    end

    wb_fifo #(
        .DEPTH (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (fifo_push),
        .push_entry (ld_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Register-file write port; address and data hold when nothing is selected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_wb_valid <= 1'b0;
            rd_wb       <= '0;
            wb_data     <= '0;
        end else begin
            rd_wb_valid <= sel_valid;
            if (sel_valid) begin
                rd_wb   <= sel_entry.rd;
                wb_data <= sel_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        hazard;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rd_wb_valid;
    logic [4:0]  rd_wb;
    logic [31:0] wb_data;
`ifdef WB_BYPASS_EN
    logic        rs1_fwd_valid, rs2_fwd_valid;
`endif

    reg_writeback_unit #(.XLEN(32), .LD_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rd_wb_valid(rd_wb_valid), .rd_wb(rd_wb), .wb_data(wb_data)
`ifdef WB_BYPASS_EN
        , .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    wb_entry_t m_q[$];
    bit [31:0] m_pend;
    bit        m_wbv;
    bit [4:0]  m_wbrd;
    bit [31:0] m_wbdata;

    logic smp_ready, smp_haz;
    bit   last_xfer;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_r;
        logic [31:0] alu_d;
        logic        ld_v;
        logic [4:0]  ld_r;
        logic [31:0] ld_d;
        logic        exp_rdy;
        logic        exp_v;
        logic [4:0]  exp_rd;
        logic [31:0] exp_d;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_pend   = '0;
        m_wbv    = 1'b0;
        m_wbrd   = '0;
        m_wbdata = '0;
    endtask

    function automatic bit m_haz();
        bit h1, h2, h3;
        h1 = (issue_rs1 != 0) && m_pend[issue_rs1];
        h2 = (issue_rs2 != 0) && m_pend[issue_rs2];
        h3 = (issue_rd  != 0) && m_pend[issue_rd];
`ifdef WB_BYPASS_EN
        if (m_wbv && m_wbrd == issue_rs1) h1 = 1'b0;
        if (m_wbv && m_wbrd == issue_rs2) h2 = 1'b0;
        if (m_wbv && m_wbrd == issue_rd)  h3 = 1'b0;
`endif
        return h1 || h2 || h3;
    endfunction

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check the registered write port just after the edge.
    task automatic step();
        bit rdy, h, keep, ov;
        wb_entry_t out, ldin;
        @(negedge clk);
        rdy = (m_q.size() < DEPTH);
        h   = m_haz();
        smp_ready = ld_ready;
        smp_haz   = hazard;
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, rdy});
        chk("hazard", {31'b0, hazard}, {31'b0, h});
        last_xfer = ld_valid && rdy;
        keep = last_xfer && (ld_rd != 0);
        ldin = '{rd: ld_rd, data: ld_data};
        ov = 0;
        out = '0;
        if (alu_valid && alu_rd != 0) begin
            ov = 1; out = '{rd: alu_rd, data: alu_data};
            if (keep) m_q.push_back(ldin);
        end else if (m_q.size() > 0) begin
            ov = 1; out = m_q.pop_front();
            if (keep) m_q.push_back(ldin);
        end else if (keep) begin
            ov = 1; out = ldin;
        end
        if (m_wbv) m_pend[m_wbrd] = 1'b0;
        if (issue_valid && !h && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        m_wbv = ov;
        if (ov) begin
            m_wbrd = out.rd; m_wbdata = out.data;
        end
        @(posedge clk);
        #1;
        chk("rd_wb_valid", {31'b0, rd_wb_valid}, {31'b0, m_wbv});
        chk("rd_wb", {27'b0, rd_wb}, {27'b0, m_wbrd});
        chk("wb_data", wb_data, m_wbdata);
    endtask

    initial begin
        int outs[$];
        int li;
        int cyc;

        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 1, 5, 32'hDEADBEEF};
        vecs[1] = '{1, 3, 32'h33,       1, 4, 32'h44,     1, 1, 3, 32'h33};
        vecs[2] = '{0, 0, 0,            0, 0, 0,          1, 1, 4, 32'h44};
        vecs[3] = '{0, 0, 0,            0, 0, 0,          1, 0, 4, 32'h44};
        vecs[4] = '{1, 0, 32'h11,       1, 0, 32'h22,     1, 0, 4, 32'h44};
        vecs[5] = '{0, 0, 0,            1, 9, 32'h99,     1, 1, 9, 32'h99};

        idle_inputs();
        rstn = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wbv", {31'b0, rd_wb_valid}, 32'd0);
        chk("rst_rd", {27'b0, rd_wb}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_hazard", {31'b0, hazard}, 32'd0);
        rstn = 1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_r; alu_data = vecs[i].alu_d;
            ld_valid = vecs[i].ld_v; ld_rd = vecs[i].ld_r; ld_data = vecs[i].ld_d;
            step();
            chk("vec_ready", {31'b0, smp_ready}, {31'b0, vecs[i].exp_rdy});
            chk("vec_wbv", {31'b0, rd_wb_valid}, {31'b0, vecs[i].exp_v});
            chk("vec_rd", {27'b0, rd_wb}, {27'b0, vecs[i].exp_rd});
            chk("vec_data", wb_data, vecs[i].exp_d);
        end
        idle_inputs();
        step();

        // RAW hazard on x7 until its writeback
        issue_valid = 1; issue_rd = 7;
        step();
        chk("haz_issue", {31'b0, smp_haz}, 32'd0);
        issue_rd = 0; issue_rs1 = 7;
        step();
        chk("haz_raw0", {31'b0, smp_haz}, 32'd1);
        step();
        chk("haz_raw1", {31'b0, smp_haz}, 32'd1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7777;
        step();
        chk("haz_alu", {31'b0, smp_haz}, 32'd1);
        alu_valid = 0; alu_rd = 0;
        step();
`ifdef WB_BYPASS_EN
        chk("haz_wb", {31'b0, smp_haz}, 32'd0);
`else
        chk("haz_wb", {31'b0, smp_haz}, 32'd1);
`endif
        step();
        chk("haz_after", {31'b0, smp_haz}, 32'd0);
        idle_inputs();

        // ALU held for 6 cycles while loads stream in
        li = 0;
        outs.delete();
        cyc = 0;
        while ((li < 6 || m_q.size() > 0 || rd_wb_valid) && cyc < 40) begin
            alu_valid = (cyc < 6);
            alu_rd    = 5'(10 + cyc);
            alu_data  = 32'(cyc);
            ld_valid  = (li < 6);
            ld_rd     = 5'(20 + li);
            ld_data   = 32'h1000 + 32'(li);
            step();
            if (cyc == 4 || cyc == 5) chk("stream_full", {31'b0, smp_ready}, 32'd0);
            if (last_xfer) li++;
            if (rd_wb_valid) outs.push_back(int'(rd_wb));
            cyc++;
        end
        chk("stream_bound", cyc, (cyc < 40) ? cyc : 0);
        chk("stream_count", outs.size(), 12);
        for (int k = 0; k < 12 && k < outs.size(); k++)
            chk("stream_order", outs[k], (k < 6) ? 10 + k : 20 + k - 6);
        idle_inputs();

        // Reset with 3 loads queued and a pending bit set
        for (int k = 0; k < 3; k++) begin
            issue_valid = (k == 0); issue_rd = 12;
            alu_valid = 1; alu_rd = 5'(1 + k); alu_data = 32'hA0 + 32'(k);
            ld_valid = 1; ld_rd = 5'(21 + k); ld_data = 32'hB0 + 32'(k);
            step();
        end
        idle_inputs();
        issue_rs1 = 12;
        chk("pre_rst_queued", m_q.size(), 3);
        rstn = 0;
        #2;
        m_reset();
        chk("mid_rst_wbv", {31'b0, rd_wb_valid}, 32'd0);
        chk("mid_rst_rd", {27'b0, rd_wb}, 32'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        chk("mid_rst_ready", {31'b0, ld_ready}, 32'd1);
        chk("mid_rst_hazard", {31'b0, hazard}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_nowrite", {31'b0, rd_wb_valid}, 32'd0);
        end
        issue_rs1 = 0;

        // Randomized traffic
        last_xfer = 0;
        for (int n = 0; n < 400; n++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            if (!(ld_valid && !last_xfer)) begin
                ld_valid = ($urandom_range(0, 1) == 1);
                ld_rd    = 5'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            step();
        end
        idle_inputs();
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
